// File: rtl/bist_misr.sv
// -----------------------------------------------------------------------------
// bist_misr
// Multiple-input signature register (MISR) for logic BIST.
//
// While the BIST controller holds run high, the block folds one response word
// per clock into a Galois-style LFSR signature. When bist_end arrives, it
// compares the signature with the fault-free GOLDEN value. The result then
// stays on the outputs until the next run starts.
//
// Parameters
//   WIDTH  : width of resp and of the signature register
//   POLY   : feedback taps, without the implicit x^WIDTH term
//   SEED   : signature value loaded at every compaction start
//   GOLDEN : expected fault-free signature
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active low
//   run        in   compaction enable from the BIST controller
//   bist_end   in   end-of-test strobe from the BIST controller
//   resp       in   CUT response word, absorbed on each compacting edge
//   signature  out  current MISR contents
//   cycles     out  response words absorbed since the last start (saturates)
//   busy       out  high in COMPACT and COMPARE
//   sig_valid  out  high in DONE
//   pass       out  signature matched GOLDEN at the compare
//   fail       out  signature differed from GOLDEN at the compare
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for run; after reset no result is held
// COMPACT | absorbing resp while run=1, pausing while run=0
// COMPARE | single cycle; latches pass/fail against GOLDEN
// DONE    | result held, sig_valid=1; run restarts compaction
// -----------------------------------------------------------------------------
module bist_misr #(
    parameter int unsigned            WIDTH  = 16,
    parameter logic [WIDTH-1:0]       POLY   = 16'h1021,
    parameter logic [WIDTH-1:0]       SEED   = '0,
    parameter logic [WIDTH-1:0]       GOLDEN = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             bist_end,
    input  logic [WIDTH-1:0] resp,
    output logic [WIDTH-1:0] signature,
    output logic [15:0]      cycles,
    output logic             busy,
    output logic             sig_valid,
    output logic             pass,
    output logic             fail
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [15:0]      cycles_q, cycles_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;

    logic [WIDTH-1:0] sig_next;
    logic             sig_match;

    // The shifted-out MSB only selects the feedback taps and is then dropped.
    assign sig_next  = {sig_q[WIDTH-2:0], 1'b0}
                     ^ (sig_q[WIDTH-1] ? POLY : '0)
                     ^ resp;
    assign sig_match = (sig_q == GOLDEN);

    always_comb begin
        state_d  = state_q;
        sig_d    = sig_q;
        cycles_d = cycles_q;
        pass_d   = pass_q;
        fail_d   = fail_q;

        case (state_q)
            IDLE, DONE: begin
                // bist_end is ignored here; only run starts a new test.
                if (run) begin
                    state_d  = COMPACT;
                    sig_d    = SEED;
                    cycles_d = '0;
                    pass_d   = 1'b0;
                    fail_d   = 1'b0;
                end
            end
            COMPACT: begin
                // bist_end takes priority: the word on resp at that edge is
                // not absorbed.
                if (bist_end) begin
                    state_d = COMPARE;
                end else if (run) begin
                    sig_d = sig_next;
                    if (cycles_q != 16'hFFFF) begin
                        cycles_d = cycles_q + 16'd1;
                    end
                end
            end
            COMPARE: begin
                state_d = DONE;
                pass_d  = sig_match;
                fail_d  = ~sig_match;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            sig_q    <= SEED;
            cycles_q <= '0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sig_q    <= sig_d;
            cycles_q <= cycles_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
        end
    end

    assign signature = sig_q;
    assign cycles    = cycles_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign busy      = (state_q == COMPACT) || (state_q == COMPARE);
    assign sig_valid = (state_q == DONE);

endmodule

// File: tb/tb_bist_misr.sv
// -----------------------------------------------------------------------------
// tb_bist_misr
// Directed bench for bist_misr with WIDTH=4, POLY=4'h3, SEED=0, GOLDEN=4'h3.
// A phase-level reference model runs beside the DUT and is compared with it on
// every negative clock edge while reset is released. Literal checks pin the
// hand-computed signature sequences.
// -----------------------------------------------------------------------------
module tb_bist_misr;

    localparam int W          = 4;
    localparam int POLY_I     = 3;
    localparam int SEED_I     = 0;
    localparam int GOLDEN_I   = 3;

    logic         clk;
    logic         rst;
    logic         run;
    logic         bist_end;
    logic [W-1:0] resp;
    logic [W-1:0] signature;
    logic [15:0]  cycles;
    logic         busy;
    logic         sig_valid;
    logic         pass;
    logic         fail;

    int n_tests = 0;
    int n_fail  = 0;

    bist_misr #(
        .WIDTH (W),
        .POLY  (4'h3),
        .SEED  (4'h0),
        .GOLDEN(4'h3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .bist_end (bist_end),
        .resp     (resp),
        .signature(signature),
        .cycles   (cycles),
        .busy     (busy),
        .sig_valid(sig_valid),
        .pass     (pass),
        .fail     (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 compacting, 2 comparing, 3 result held
    int m_phase;
    int m_sig;
    int m_cyc;
    int m_pass;
    int m_fail;

    // Multiply the signature by x modulo (x^4 + POLY), then add the response.
    function automatic int misr_step(input int s, input int r);
        int v;
        v = (s * 2) % (1 << W);
        if (s >= (1 << (W - 1))) v = v ^ POLY_I;
        return v ^ r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0;
            m_sig   = SEED_I;
            m_cyc   = 0;
            m_pass  = 0;
            m_fail  = 0;
        end else begin
            if (m_phase == 0 || m_phase == 3) begin
                if (run) begin
                    m_phase = 1;
                    m_sig   = SEED_I;
                    m_cyc   = 0;
                    m_pass  = 0;
                    m_fail  = 0;
                end
            end else if (m_phase == 1) begin
                if (bist_end) begin
                    m_phase = 2;
                end else if (run) begin
                    m_sig = misr_step(m_sig, int'(resp));
                    if (m_cyc < 65535) m_cyc = m_cyc + 1;
                end
            end else begin
                m_pass  = (m_sig == GOLDEN_I) ? 1 : 0;
                m_fail  = 1 - m_pass;
                m_phase = 3;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            check("model_sig",   32'(signature), 32'(m_sig));
            check("model_cyc",   32'(cycles),    32'(m_cyc));
            check("model_busy",  32'(busy),      32'((m_phase == 1 || m_phase == 2) ? 1 : 0));
            check("model_valid", 32'(sig_valid), 32'((m_phase == 3) ? 1 : 0));
            check("model_pass",  32'(pass),      32'(m_pass));
            check("model_fail",  32'(fail),      32'(m_fail));
            if (pass && fail) check("pass_and_fail", 32'(1), 32'(0));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_run();
        run = 1'b1;
        @(negedge clk);
        check("start_busy",  32'(busy),      32'(1));
        check("start_valid", 32'(sig_valid), 32'(0));
        check("start_sig",   32'(signature), 32'(0));
        check("start_cyc",   32'(cycles),    32'(0));
        check("start_pass",  32'(pass),      32'(0));
        check("start_fail",  32'(fail),      32'(0));
    endtask

    task automatic absorb(input logic [W-1:0] r, input logic [W-1:0] exp_sig);
        resp = r;
        @(negedge clk);
        check("absorb_sig", 32'(signature), 32'(exp_sig));
    endtask

    task automatic finish_run(input logic exp_pass, input logic [W-1:0] exp_sig);
        bist_end = 1'b1;
        resp     = 4'hF;
        @(negedge clk);
        check("compare_busy", 32'(busy),      32'(1));
        check("compare_sig",  32'(signature), 32'(exp_sig));
        bist_end = 1'b0;
        run      = 1'b0;
        @(negedge clk);
        check("done_valid", 32'(sig_valid), 32'(1));
        check("done_busy",  32'(busy),      32'(0));
        check("done_pass",  32'(pass),      32'(exp_pass));
        check("done_fail",  32'(fail),      32'(!exp_pass));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst      = 1'b0;
        run      = 1'b0;
        bist_end = 1'b0;
        resp     = '0;
        #3;
        check("rst_sig",   32'(signature), 32'(0));
        check("rst_cyc",   32'(cycles),    32'(0));
        check("rst_busy",  32'(busy),      32'(0));
        check("rst_valid", 32'(sig_valid), 32'(0));
        check("rst_pass",  32'(pass),      32'(0));
        check("rst_fail",  32'(fail),      32'(0));

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'(0));

        // Basic compaction: 1,2,4,8,3 -> pass
        start_run();
        absorb(4'h1, 4'h1);
        absorb(4'h0, 4'h2);
        absorb(4'h0, 4'h4);
        absorb(4'h0, 4'h8);
        absorb(4'h0, 4'h3);
        check("basic_cyc", 32'(cycles), 32'(5));
        finish_run(1'b1, 4'h3);

        // Pause mid-test with resp toggling
        start_run();
        absorb(4'h1, 4'h1);
        absorb(4'h0, 4'h2);
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            resp = (i % 2 == 0) ? 4'hF : 4'h5;
            @(negedge clk);
            check("pause_sig", 32'(signature), 32'(2));
            check("pause_cyc", 32'(cycles),    32'(2));
        end
        run = 1'b1;
        absorb(4'h0, 4'h4);
        absorb(4'h0, 4'h8);
        absorb(4'h0, 4'h3);
        check("pause_final_cyc", 32'(cycles), 32'(5));
        finish_run(1'b1, 4'h3);

        // Mid-test reset, then bist_end in IDLE is ignored
        start_run();
        absorb(4'h1, 4'h1);
        absorb(4'h0, 4'h2);
        #2;
        rst = 1'b0;
        #1;
        check("arst_sig",   32'(signature), 32'(0));
        check("arst_cyc",   32'(cycles),    32'(0));
        check("arst_busy",  32'(busy),      32'(0));
        check("arst_valid", 32'(sig_valid), 32'(0));
        run = 1'b0;
        @(negedge clk);
        rst      = 1'b1;
        bist_end = 1'b1;
        @(negedge clk);
        check("idle_bend_valid", 32'(sig_valid), 32'(0));
        check("idle_bend_busy",  32'(busy),      32'(0));
        bist_end = 1'b0;
        @(negedge clk);
        check("idle_bend_valid2", 32'(sig_valid), 32'(0));

        // Mismatch: 1,2,5,A,7 -> fail
        start_run();
        absorb(4'h1, 4'h1);
        absorb(4'h0, 4'h2);
        absorb(4'h1, 4'h5);
        absorb(4'h0, 4'hA);
        absorb(4'h0, 4'h7);
        finish_run(1'b0, 4'h7);

        // bist_end in DONE is ignored
        bist_end = 1'b1;
        @(negedge clk);
        check("done_bend_valid", 32'(sig_valid), 32'(1));
        check("done_bend_fail",  32'(fail),      32'(1));
        bist_end = 1'b0;

        // Restart from DONE, then saturate the cycle counter
        start_run();
        for (int i = 0; i < 65540; i++) begin
            resp = W'($urandom_range(0, 15));
            @(negedge clk);
        end
        check("sat_cyc",  32'(cycles), 32'(16'hFFFF));
        check("sat_busy", 32'(busy),   32'(1));
        bist_end = 1'b1;
        @(negedge clk);
        bist_end = 1'b0;
        run      = 1'b0;
        @(negedge clk);
        check("sat_valid",    32'(sig_valid),   32'(1));
        check("sat_onehot",   32'(pass ^ fail), 32'(1));
        check("sat_cyc_hold", 32'(cycles),      32'(16'hFFFF));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bist_misr.md
BIST_MISR -- requirements
Module: bist_misr

Interface
REQ-001 Parameter WIDTH, default 16: width of the response bus and the signature register.
REQ-002 Parameter POLY, default 16'h1021: feedback taps, excluding the implicit x^WIDTH term.
REQ-003 Parameter SEED, default 0: value loaded into the signature register at every compaction start.
REQ-004 Parameter GOLDEN, default 0: expected fault-free signature.
REQ-005 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-low.
REQ-007 Port run, input, 1: compaction enable from the BIST controller's OUT output.
REQ-008 Port bist_end, input, 1: end-of-test strobe from the BIST controller's BIST_END output.
REQ-009 Port resp, input, WIDTH: circuit-under-test response word sampled each compacting cycle.
REQ-010 Port signature, output, WIDTH: current MISR contents.
REQ-011 Port cycles, output, 16: number of response words absorbed since the last start.
REQ-012 Port busy, output, 1: high in COMPACT and COMPARE.
REQ-013 Port sig_valid, output, 1: high while in DONE.
REQ-014 Port pass, output, 1: signature equalled GOLDEN at the compare.
REQ-015 Port fail, output, 1: signature differed from GOLDEN at the compare.

Function
REQ-016 The FSM shall have exactly four states: IDLE, COMPACT, COMPARE and DONE.
REQ-017 In IDLE with run=1, the block shall load signature<=SEED, clear cycles to 0, clear pass and fail, and enter COMPACT; resp is not absorbed on this edge.
REQ-018 In COMPACT with run=1 and bist_end=0, each edge shall update signature<={signature[WIDTH-2:0],1'b0} ^ (signature[WIDTH-1] ? POLY : 0) ^ resp.
REQ-019 On the same edge as REQ-018, cycles shall increment, saturating at 16'hFFFF.
REQ-020 In COMPACT with run=0 and bist_end=0, signature and cycles shall hold (pause).
REQ-021 In COMPACT with bist_end=1, the block shall enter COMPARE regardless of run; bist_end has priority, and resp is not absorbed on that edge.
REQ-022 COMPARE shall last exactly one cycle: on exit, pass<=(signature==GOLDEN), fail<=~(signature==GOLDEN), then enter DONE.
REQ-023 In DONE, signature, cycles, pass and fail shall hold, and sig_valid shall be 1.
REQ-024 In DONE, run=1 shall behave as REQ-017: reload SEED, clear results, drop sig_valid, and enter COMPACT.
REQ-025 bist_end in IDLE or DONE shall be ignored.
REQ-026 pass and fail shall never be 1 simultaneously.
REQ-027 busy and sig_valid shall be Moore outputs decoded from state only.
REQ-028 Signature arithmetic shall be pure XOR/shift at WIDTH bits; the shifted-out MSB is discarded after selecting the feedback.

Reset
REQ-029 While rst=0, the block shall immediately force state=IDLE, signature=SEED, cycles=0, busy=0, sig_valid=0, pass=0 and fail=0, independent of clk.
REQ-030 Reset asserted mid-COMPACT or mid-COMPARE shall abort with no result; after release, a new run is required to start.
REQ-031 The first active edge after rst rises shall obey the IDLE rules of REQ-017 and REQ-025.

Verification
REQ-032 Basic compaction (WIDTH=4, POLY=4'h3, SEED=0, GOLDEN=4'h3): run=1; resp=1,0,0,0,0 on successive edges; then bist_end -> signatures 1,2,4,8,3; cycles=5; pass=1 and fail=0 one cycle after bist_end; sig_valid=1.
REQ-033 Mismatch: same as REQ-032 with third resp=1 (signatures 1,2,5,A, then 7) -> fail=1, pass=0.
REQ-034 Pause: drop run for 3 cycles mid-test with resp toggling -> signature and cycles unchanged during the pause; final result identical to REQ-032.
REQ-035 Mid-test reset: rst=0 after 2 absorbed words -> asynchronously signature=0, cycles=0, busy=0; bist_end after release -> ignored, sig_valid stays 0.
REQ-036 Restart from DONE: after REQ-033, raise run -> sig_valid=0, fail=0, signature=SEED, cycles=0, busy=1.
REQ-037 Saturation: hold run=1 for 65540 cycles -> cycles stops at 16'hFFFF while signature keeps updating.
